// File: rtl/axi_register_bank.sv
// ---------------------------------------------------------------------------
// axi_register_bank
//   AXI4-Lite slave exposing REG_COUNT registers of DATA_WIDTH bits inside an
//   address window that starts at BASEADDR. Each register is plain read/write,
//   read-only (RO_MASK) or sticky write-1-to-clear status (W1C_MASK). The
//   hardware side can load (RW/RO) or set bits (W1C) through REG_IN.
//
// Ports
//   CLK, RESET          : sole clock, asynchronous active-high reset
//   AW*/W*/B*           : AXI4-Lite write address, write data, write response
//   AR*/R*              : AXI4-Lite read address, read data
//   REG_IN/REG_IN_VALID : hardware-side update, register i in slice i
//   REG_OUT             : current register contents, register i in slice i
//   REG_OUT_VALID       : one-cycle pulse after a successful AXI write to i
// ---------------------------------------------------------------------------
module axi_register_bank #(
    parameter int                                DATA_WIDTH = 32,
    parameter int                                ADDR_WIDTH = 32,
    parameter int                                REG_COUNT  = 8,
    parameter logic [ADDR_WIDTH-1:0]             BASEADDR   = {ADDR_WIDTH{1'b0}},
    parameter logic [REG_COUNT-1:0]              RO_MASK    = {REG_COUNT{1'b0}},
    parameter logic [REG_COUNT-1:0]              W1C_MASK   = {REG_COUNT{1'b0}},
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]   REG_INIT   = {(REG_COUNT*DATA_WIDTH){1'b0}}
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [ADDR_WIDTH-1:0]            AWADDR,
    input  logic                             AWVALID,
    output logic                             AWREADY,
    input  logic [DATA_WIDTH-1:0]            WDATA,
    input  logic [DATA_WIDTH/8-1:0]          WSTRB,
    input  logic                             WVALID,
    output logic                             WREADY,
    output logic [1:0]                       BRESP,
    output logic                             BVALID,
    input  logic                             BREADY,
    input  logic [ADDR_WIDTH-1:0]            ARADDR,
    input  logic                             ARVALID,
    output logic                             ARREADY,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic [1:0]                       RRESP,
    output logic                             RVALID,
    input  logic                             RREADY,
    input  logic [REG_COUNT*DATA_WIDTH-1:0]  REG_IN,
    input  logic [REG_COUNT-1:0]             REG_IN_VALID,
    output logic [REG_COUNT*DATA_WIDTH-1:0]  REG_OUT,
    output logic [REG_COUNT-1:0]             REG_OUT_VALID
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ALSB     = $clog2(STRB_W);
    localparam int IW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int WIN_BITS = $clog2(REG_COUNT * STRB_W);

    // Address bits below the window size; everything above must match BASEADDR.
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        (ADDR_WIDTH'(1'b1) << WIN_BITS) - ADDR_WIDTH'(1'b1);
    localparam logic [8:0] REG_COUNT_W = 9'(REG_COUNT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Word index of an address inside the window.
    function automatic logic [IW-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ALSB +: IW];
    endfunction

    // True when the address hits an implemented register of this bank.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [IW-1:0] idx;
        idx = addr[ALSB +: IW];
        return (((addr ^ BASEADDR) & ~OFFSET_MASK) == {ADDR_WIDTH{1'b0}}) &&
               (9'(idx) < REG_COUNT_W);
    endfunction

    // Expand byte strobes into a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_WIDTH-1:0] mask;
        mask = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < STRB_W; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

    // Write-channel state: AW and W are captured independently until both exist.
    logic                                   aw_held_r;
    logic [ADDR_WIDTH-1:0]                  awaddr_r;
    logic                                   w_held_r;
    logic [DATA_WIDTH-1:0]                  wdata_r;
    logic [STRB_W-1:0]                      wstrb_r;
    logic                                   bvalid_r;
    logic [1:0]                             bresp_r;

    // Read-channel state.
    logic                                   rvalid_r;
    logic [1:0]                             rresp_r;
    logic [DATA_WIDTH-1:0]                  rdata_r;

    // Register storage.
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0]   regs_r;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0]   regs_next_s;
    logic [REG_COUNT-1:0]                   reg_out_valid_r;
    logic [REG_COUNT-1:0]                   reg_out_valid_next_s;

    logic                                   awready_s;
    logic                                   wready_s;
    logic                                   arready_s;
    logic                                   aw_hs_s;
    logic                                   w_hs_s;
    logic                                   ar_hs_s;
    logic                                   commit_s;
    logic                                   wr_ok_s;
    logic [ADDR_WIDTH-1:0]                  wr_addr_s;
    logic [DATA_WIDTH-1:0]                  wr_data_s;
    logic [STRB_W-1:0]                      wr_strb_s;
    logic [DATA_WIDTH-1:0]                  wr_mask_s;
    logic [IW-1:0]                          wr_idx_s;
    logic [1:0]                             wr_resp_s;
    logic [IW-1:0]                          rd_idx_s;
    logic [1:0]                             rd_resp_s;
    logic [DATA_WIDTH-1:0]                  rd_word_s;

    assign AWREADY       = awready_s;
    assign WREADY        = wready_s;
    assign ARREADY       = arready_s;
    assign BVALID        = bvalid_r;
    assign BRESP         = bresp_r;
    assign RVALID        = rvalid_r;
    assign RRESP         = rresp_r;
    assign RDATA         = rdata_r;
    assign REG_OUT       = regs_r;
    assign REG_OUT_VALID = reg_out_valid_r;

    // Ready generation: a pending write response stalls both write channels.
    always_comb begin
        awready_s = ~aw_held_r & ~bvalid_r & ~RESET;
        wready_s  = ~w_held_r  & ~bvalid_r & ~RESET;
        arready_s = ~rvalid_r  & ~RESET;
        aw_hs_s   = AWVALID & awready_s;
        w_hs_s    = WVALID  & wready_s;
        ar_hs_s   = ARVALID & arready_s;
    end

    // Write decode: use the held copy if present, otherwise the live handshake.
    always_comb begin
        if (aw_held_r) begin
            wr_addr_s = awaddr_r;
        end else begin
            wr_addr_s = AWADDR;
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = WDATA;
            wr_strb_s = WSTRB;
        end
        commit_s = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
        wr_idx_s = word_index(wr_addr_s);
        if (!in_window(wr_addr_s)) begin
            wr_resp_s = RESP_DECERR;
        end else if (RO_MASK[wr_idx_s]) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
        wr_ok_s   = commit_s & (wr_resp_s == RESP_OKAY);
        wr_mask_s = strb_to_mask(wr_strb_s);
    end

    // Next register values: AXI write wins on RW, hardware set wins on W1C.
    always_comb begin
        logic                  wr_hit;
        logic [DATA_WIDTH-1:0] hw_word;
        logic [DATA_WIDTH-1:0] clr_bits;
        logic [DATA_WIDTH-1:0] set_bits;
        regs_next_s          = regs_r;
        reg_out_valid_next_s = {REG_COUNT{1'b0}};
        wr_hit               = 1'b0;
        hw_word              = {DATA_WIDTH{1'b0}};
        clr_bits             = {DATA_WIDTH{1'b0}};
        set_bits             = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < REG_COUNT; i++) begin
            wr_hit  = wr_ok_s && (wr_idx_s == IW'(i));
            hw_word = REG_IN[i*DATA_WIDTH +: DATA_WIDTH];
            if (wr_hit) begin
                clr_bits = wr_data_s & wr_mask_s;
            end else begin
                clr_bits = {DATA_WIDTH{1'b0}};
            end
            if (REG_IN_VALID[i]) begin
                set_bits = hw_word;
            end else begin
                set_bits = {DATA_WIDTH{1'b0}};
            end
            if (W1C_MASK[i]) begin
                regs_next_s[i] = (regs_r[i] & ~clr_bits) | set_bits;
            end else if (wr_hit) begin
                regs_next_s[i] = (regs_r[i] & ~wr_mask_s) | (wr_data_s & wr_mask_s);
            end else if (REG_IN_VALID[i]) begin
                regs_next_s[i] = hw_word;
            end else begin
                regs_next_s[i] = regs_r[i];
            end
            if (wr_hit && (wr_strb_s != {STRB_W{1'b0}})) begin
                reg_out_valid_next_s[i] = 1'b1;
            end else begin
                reg_out_valid_next_s[i] = 1'b0;
            end
        end
    end

    // Read decode: out-of-window reads return zero with DECERR.
    always_comb begin
        rd_idx_s = word_index(ARADDR);
        if (in_window(ARADDR)) begin
            rd_word_s = regs_r[rd_idx_s];
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_word_s = {DATA_WIDTH{1'b0}};
            rd_resp_s = RESP_DECERR;
        end
    end

    // Write channel: capture AW/W, commit when both present, hold response until BREADY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            aw_held_r <= 1'b0;
            awaddr_r  <= {ADDR_WIDTH{1'b0}};
            w_held_r  <= 1'b0;
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {STRB_W{1'b0}};
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bresp_r   <= wr_resp_s;
            end else begin
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    awaddr_r  <= AWADDR;
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    wdata_r  <= WDATA;
                    wstrb_r  <= WSTRB;
                end
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
            end else if (bvalid_r && BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Register storage and write-notification pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_r          <= REG_INIT;
            reg_out_valid_r <= {REG_COUNT{1'b0}};
        end else begin
            regs_r          <= regs_next_s;
            reg_out_valid_r <= reg_out_valid_next_s;
        end
    end

    // Read channel: sample register value at AR handshake, hold until RREADY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            rresp_r  <= 2'b00;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_word_s;
            rresp_r  <= rd_resp_s;
        end else if (rvalid_r && RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_register_bank.sv
// ---------------------------------------------------------------------------
// tb_axi_register_bank
//   Directed and randomized bench for axi_register_bank configured with
//   5 registers at 0x4000_0000 (reg1 read-only, reg3 write-1-to-clear).
//   Expected values come from a register-array model of the bank's rules.
// ---------------------------------------------------------------------------
module tb_axi_register_bank;

    localparam logic [31:0]  BASE = 32'h4000_0000;
    localparam int           NREG = 5;
    localparam logic [4:0]   RO   = 5'b00010;
    localparam logic [4:0]   W1C  = 5'b01000;
    localparam logic [159:0] INIT = {32'h4444_0004, 32'h0000_00F0, 32'h0000_0000,
                                     32'h1111_0001, 32'hA5A5_0000};

    logic         CLK;
    logic         RESET;
    logic [31:0]  AWADDR;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [159:0] REG_IN;
    logic [4:0]   REG_IN_VALID;
    logic [159:0] REG_OUT;
    logic [4:0]   REG_OUT_VALID;

    int n_vectors;
    int n_miscompares;

    logic [31:0] m_regs [NREG];
    logic [1:0]  last_bresp;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    axi_register_bank #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .REG_COUNT  (NREG),
        .BASEADDR   (BASE),
        .RO_MASK    (RO),
        .W1C_MASK   (W1C),
        .REG_INIT   (INIT)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AWADDR        (AWADDR),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .BRESP         (BRESP),
        .BVALID        (BVALID),
        .BREADY        (BREADY),
        .ARADDR        (ARADDR),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .REG_IN        (REG_IN),
        .REG_IN_VALID  (REG_IN_VALID),
        .REG_OUT       (REG_OUT),
        .REG_OUT_VALID (REG_OUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point for the whole bench.
    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_in_window(input logic [31:0] addr);
        return (addr >= BASE) && ((addr - BASE) < 32'd20);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = INIT[i*32 +: 32];
    endtask

    // One clock edge: optional AXI write commit plus hardware updates.
    task automatic model_edge(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [4:0] hv, input logic [159:0] hd,
                              output logic [1:0] resp, output logic [4:0] pulse);
        int          idx;
        logic [31:0] mask;
        logic [31:0] clr;
        bit          ok;
        idx  = int'((addr - BASE) >> 2);
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
        if (!m_in_window(addr)) resp = 2'b11;
        else if (RO[idx])       resp = 2'b10;
        else                    resp = 2'b00;
        ok    = wr && (resp == 2'b00);
        pulse = (ok && strb != 4'h0) ? 5'(1 << idx) : 5'b0;
        for (int i = 0; i < NREG; i++) begin
            if (W1C[i]) begin
                clr = (ok && i == idx) ? (data & mask) : 32'h0;
                m_regs[i] = (m_regs[i] & ~clr) | (hv[i] ? hd[i*32 +: 32] : 32'h0);
            end else if (ok && i == idx) begin
                m_regs[i] = (m_regs[i] & ~mask) | (data & mask);
            end else if (hv[i]) begin
                m_regs[i] = hd[i*32 +: 32];
            end
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < NREG; i++)
            check_value($sformatf("reg%0d", i), REG_OUT[i*32 +: 32], m_regs[i]);
    endtask

    // ---------------- bus tasks (entered #1 after a rising edge) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [4:0] hv, input logic [159:0] hd);
        logic [1:0] exp_resp;
        logic [4:0] exp_pulse;
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc, cmax;
        aw_done = 0; w_done = 0; cyc = 0;
        cmax = (aw_dly > w_dly) ? aw_dly : w_dly;
        AWADDR = addr; WDATA = data; WSTRB = strb; REG_IN = hd;
        while (!(aw_done && w_done) && cyc < 40) begin
            AWVALID      = !aw_done && (cyc >= aw_dly);
            WVALID       = !w_done && (cyc >= w_dly);
            REG_IN_VALID = (cyc == cmax) ? hv : 5'b0;
            @(negedge CLK);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge CLK); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0; REG_IN_VALID = 5'b0;
        check_value("wr_handshake", {62'b0, aw_done, w_done}, 64'h3);
        model_edge(1'b1, addr, data, strb, hv, hd, exp_resp, exp_pulse);
        cyc = 0;
        while (!BVALID && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check_value("bvalid", BVALID, 1);
        check_value("bresp", BRESP, exp_resp);
        check_value("reg_out_valid", REG_OUT_VALID, exp_pulse);
        last_bresp = BRESP;
        for (int k = 0; k < b_dly; k++) begin
            @(posedge CLK); #1;
            check_value("bvalid_hold", BVALID, 1);
            check_value("bresp_hold", BRESP, exp_resp);
            check_value("awready_stall", AWREADY, 0);
            check_value("wready_stall", WREADY, 0);
            if (k == 0) check_value("pulse_end", REG_OUT_VALID, 0);
        end
        BREADY = 1'b1;
        @(posedge CLK); #1;
        BREADY = 1'b0;
        check_value("bvalid_clear", BVALID, 0);
        check_regs();
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit done, fire;
        int cyc;
        exp_data = m_in_window(addr) ? m_regs[int'((addr - BASE) >> 2)] : 32'h0;
        exp_resp = m_in_window(addr) ? 2'b00 : 2'b11;
        done = 0; cyc = 0;
        ARADDR = addr;
        while (!done && cyc < 40) begin
            ARVALID = (cyc >= ar_dly);
            @(negedge CLK);
            fire = ARVALID && ARREADY;
            @(posedge CLK); #1;
            if (fire) done = 1;
            cyc++;
        end
        ARVALID = 1'b0;
        check_value("ar_handshake", {63'b0, done}, 64'h1);
        cyc = 0;
        while (!RVALID && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check_value("rvalid", RVALID, 1);
        check_value("rdata", RDATA, exp_data);
        check_value("rresp", RRESP, exp_resp);
        last_rdata = RDATA;
        last_rresp = RRESP;
        for (int k = 0; k < r_dly; k++) begin
            @(posedge CLK); #1;
            check_value("rvalid_hold", RVALID, 1);
            check_value("rdata_hold", RDATA, exp_data);
            check_value("arready_stall", ARREADY, 0);
        end
        RREADY = 1'b1;
        @(posedge CLK); #1;
        RREADY = 1'b0;
        check_value("rvalid_clear", RVALID, 0);
    endtask

    task automatic do_hw(input logic [4:0] hv, input logic [159:0] hd);
        logic [1:0] unused_resp;
        logic [4:0] unused_pulse;
        REG_IN = hd; REG_IN_VALID = hv;
        @(posedge CLK); #1;
        REG_IN_VALID = 5'b0;
        model_edge(1'b0, BASE, 32'h0, 4'h0, hv, hd, unused_resp, unused_pulse);
        check_value("hw_no_pulse", REG_OUT_VALID, 0);
        check_regs();
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 8)       return BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
        else if (k == 8) return BASE + 32'h1000;
        else             return $urandom;
    endfunction

    // Overall bound so that a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic [159:0] hd;
        int op;
        n_vectors = 0; n_miscompares = 0;
        RESET = 1'b1;
        AWADDR = 32'h0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = 32'h0; ARVALID = 1'b0; RREADY = 1'b0;
        REG_IN = 160'h0; REG_IN_VALID = 5'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_value("rst_awready", AWREADY, 0);
        check_value("rst_wready", WREADY, 0);
        check_value("rst_arready", ARREADY, 0);
        check_value("rst_bvalid", BVALID, 0);
        check_value("rst_rvalid", RVALID, 0);
        check_value("rst_pulse", REG_OUT_VALID, 0);
        check_regs();
        RESET = 1'b0;
        @(negedge CLK);
        check_value("rel_awready", AWREADY, 1);
        check_value("rel_wready", WREADY, 1);
        check_value("rel_arready", ARREADY, 1);
        @(posedge CLK); #1;

        // RW write, W three cycles after AW, low two bytes strobed
        do_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'h3, 0, 3, 1, 5'b0, 160'h0);
        check_value("rw_partial", REG_OUT[2*32 +: 32], 64'h0000_BEEF);
        check_value("rw_partial_resp", last_bresp, 2'b00);

        // Out-of-window write and read
        do_write(BASE + 32'h14, 32'h1234_5678, 4'hF, 0, 0, 0, 5'b0, 160'h0);
        check_value("oow_wr_resp", last_bresp, 2'b11);
        do_read(BASE + 32'h1000, 0, 0);
        check_value("oow_rd_data", last_rdata, 0);
        check_value("oow_rd_resp", last_rresp, 2'b11);

        // Read-only write, W1C clear, W1C set-vs-clear collision, RW collision
        do_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 5'b0, 160'h0);
        check_value("ro_resp", last_bresp, 2'b10);
        check_value("ro_keep", REG_OUT[1*32 +: 32], 64'h1111_0001);
        do_write(BASE + 32'hC, 32'h30, 4'hF, 0, 0, 0, 5'b0, 160'h0);
        check_value("w1c_clear", REG_OUT[3*32 +: 32], 64'hC0);
        hd = 160'h0; hd[3*32 +: 32] = 32'h10;
        do_write(BASE + 32'hC, 32'h10, 4'hF, 0, 0, 0, 5'b01000, hd);
        check_value("w1c_set_wins", REG_OUT[3*32 + 4], 1);
        hd = 160'h0; hd[0 +: 32] = 32'hFFFF_FFFF;
        do_write(BASE + 32'h0, 32'h1234_5678, 4'hC, 0, 0, 0, 5'b00001, hd);
        check_value("rw_axi_wins", REG_OUT[0 +: 32], 64'h1234_0000);
        hd = 160'h0; hd[1*32 +: 32] = 32'h0000_CAFE;
        do_hw(5'b00010, hd);
        do_read(BASE + 32'h4, 0, 0);
        check_value("ro_read_resp", last_rresp, 2'b00);

        // Backpressure on both response channels
        do_write(BASE + 32'h10, $urandom, 4'hF, 0, 0, 10, 5'b0, 160'h0);
        do_read(BASE + 32'h10, 0, 6);

        // Reset between AW and W handshakes aborts the transaction
        AWADDR = BASE + 32'h8; AWVALID = 1'b1;
        @(negedge CLK);
        check_value("abort_aw_ready", AWREADY, 1);
        @(posedge CLK); #1;
        AWVALID = 1'b0;
        check_value("abort_aw_held", AWREADY, 0);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        check_value("abort_rst_wready", WREADY, 0);
        check_value("abort_rst_bvalid", BVALID, 0);
        check_regs();
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_value("abort_awready", AWREADY, 1);
        check_value("abort_wready", WREADY, 1);
        check_value("abort_arready", ARREADY, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check_value("abort_no_bvalid", BVALID, 0);
        end
        do_write(BASE + 32'h8, 32'h5555_AAAA, 4'hF, 0, 0, 0, 5'b0, 160'h0);
        check_value("abort_next_ok", last_bresp, 2'b00);

        // Randomized mix of writes, reads and hardware updates
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            hd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (op < 5) begin
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b0, hd);
            end else if (op < 8) begin
                do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_hw(5'($urandom_range(1, 31)), hd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
